// File: rtl/truth_table_sweeper_if.sv
// rtl/truth_table_sweeper_if.sv - sweep control, DUT stimulus/response and result bundle
// master: the sweeper side; slave: the gate DUT / supervising bench side.
interface truth_table_sweeper_if #(
   parameter int N = 2,
   parameter int W = 1
) ();
   logic          start;
   logic [W-1:0]  resp;
   logic [N-1:0]  stim;
   logic          busy;
   logic          done;
   logic          pass;
   logic [N:0]    err_cnt;
   logic          first_fail_vld;
   logic [N-1:0]  first_fail_idx;

   modport master (
      input  start, resp,
      output stim, busy, done, pass, err_cnt, first_fail_vld, first_fail_idx
   );

   modport slave (
      output start, resp,
      input  stim, busy, done, pass, err_cnt, first_fail_vld, first_fail_idx
   );
endinterface

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive 2^N vector sweep, compares resp against packed EXPECT
// Optional first-failure capture is enabled by defining TTS_FIRST_FAIL_EN.
module truth_table_sweeper #(
   parameter int N = 2,
   parameter int W = 1,
   parameter int SETTLE = 1,
   parameter logic [W*(2**N)-1:0] EXPECT = 4'b1000
) (
   input  logic clk,
   input  logic rst_n,
   truth_table_sweeper_if.master bus
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_APPLY = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [7:0] SETTLE_C = 8'(SETTLE);

   state_t         state_q;
   state_t         state_d;
   logic [N-1:0]   idx_q;
   logic [7:0]     settle_q;
   logic           busy_q;
   logic           done_q;
   logic           pass_q;
   logic [N:0]     err_q;
   logic [N:0]     err_nxt;
   logic           accept;
   logic           sample;
   logic           last;
   logic           finish;
   logic           mismatch;
   logic [W-1:0]   exp_vec;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_APPLY;
         S_APPLY: if (finish) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Control decode: sampling happens on the last settle cycle of each vector.
   always_comb begin
      accept = 1'b0;
      sample = 1'b0;
      case (state_q)
         S_IDLE:  accept = bus.start;
         S_APPLY: sample = (settle_q == SETTLE_C);
         default: ;
      endcase
   end

   assign last     = &idx_q;
   assign finish   = sample && last;
   assign exp_vec  = EXPECT[int'(idx_q) * W +: W];
   assign mismatch = sample && (bus.resp != exp_vec);
   assign err_nxt  = err_q + {{N{1'b0}}, mismatch};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q    <= '0;
         settle_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         err_q    <= '0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            idx_q    <= '0;
            settle_q <= '0;
            busy_q   <= 1'b1;
            pass_q   <= 1'b0;
            err_q    <= '0;
         end else if (sample) begin
            settle_q <= '0;
            err_q    <= err_nxt;
            if (last) begin
               // idx returns to 0 so stim is idle-low during DONE.
               idx_q  <= '0;
               busy_q <= 1'b0;
               done_q <= 1'b1;
               pass_q <= (err_nxt == '0);
            end else begin
               idx_q <= idx_q + N'(1);
            end
         end else if (state_q == S_APPLY) begin
            settle_q <= settle_q + 8'd1;
         end
      end
   end

   assign bus.stim    = idx_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.pass    = pass_q;
   assign bus.err_cnt = err_q;

`ifdef TTS_FIRST_FAIL_EN
   logic         ff_vld_q;
   logic [N-1:0] ff_idx_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff_vld_q <= 1'b0;
         ff_idx_q <= '0;
      end else if (accept) begin
         ff_vld_q <= 1'b0;
         ff_idx_q <= '0;
      end else if (mismatch && !ff_vld_q) begin
         ff_vld_q <= 1'b1;
         ff_idx_q <= idx_q;
      end
   end

   assign bus.first_fail_vld = ff_vld_q;
   assign bus.first_fail_idx = ff_idx_q;
`else
   assign bus.first_fail_vld = 1'b0;
   assign bus.first_fail_idx = '0;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - randomized self-checking bench for truth_table_sweeper
module tb_truth_table_sweeper;
`ifdef TTS_FIRST_FAIL_EN
   localparam bit FFE = 1'b1;
`else
   localparam bit FFE = 1'b0;
`endif

   localparam int K_AND   = 0;
   localparam int K_OR    = 1;
   localparam int K_MAJ   = 2;
   localparam int K_EXACT = 3;
   localparam int K_RAND  = 4;
   localparam int K_FLIP  = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start_r = 1'b0;
   int   sel_r = 0;
   int   total = 0;
   int   bad = 0;
   logic [7:0] model_tbl [0:255];

   int n_of [3] = '{2, 3, 2};
   int s_of [3] = '{1, 0, 2};

   always #5 clk = ~clk;

   truth_table_sweeper_if #(.N(2), .W(1)) ia ();
   truth_table_sweeper_if #(.N(3), .W(1)) ib ();
   truth_table_sweeper_if #(.N(2), .W(2)) ic ();

   assign ia.start = start_r && (sel_r == 0);
   assign ib.start = start_r && (sel_r == 1);
   assign ic.start = start_r && (sel_r == 2);
   assign ia.resp  = model_tbl[ia.stim][0];
   assign ib.resp  = model_tbl[ib.stim][0];
   assign ic.resp  = model_tbl[ic.stim][1:0];

   truth_table_sweeper #(.N(2), .W(1), .SETTLE(1), .EXPECT(4'b1000)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ia));
   truth_table_sweeper #(.N(3), .W(1), .SETTLE(0), .EXPECT(8'b1110_1000)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ib));
   truth_table_sweeper #(.N(2), .W(2), .SETTLE(2), .EXPECT(8'b10_01_11_00)) dut_c (
      .clk(clk), .rst_n(rst_n), .bus(ic));

   logic [7:0] o_stim;
   logic       o_busy;
   logic       o_done;
   logic       o_pass;
   logic [8:0] o_err;
   logic       o_ffv;
   logic [7:0] o_ffi;

   always_comb begin
      o_stim = '0; o_busy = 1'b0; o_done = 1'b0; o_pass = 1'b0;
      o_err = '0; o_ffv = 1'b0; o_ffi = '0;
      case (sel_r)
         0: begin
            o_stim[1:0] = ia.stim; o_busy = ia.busy; o_done = ia.done; o_pass = ia.pass;
            o_err[2:0] = ia.err_cnt; o_ffv = ia.first_fail_vld; o_ffi[1:0] = ia.first_fail_idx;
         end
         1: begin
            o_stim[2:0] = ib.stim; o_busy = ib.busy; o_done = ib.done; o_pass = ib.pass;
            o_err[3:0] = ib.err_cnt; o_ffv = ib.first_fail_vld; o_ffi[2:0] = ib.first_fail_idx;
         end
         default: begin
            o_stim[1:0] = ic.stim; o_busy = ic.busy; o_done = ic.done; o_pass = ic.pass;
            o_err[2:0] = ic.err_cnt; o_ffv = ic.first_fail_vld; o_ffi[1:0] = ic.first_fail_idx;
         end
      endcase
   end

   function automatic logic [7:0] wmask(input int sel);
      return (sel == 2) ? 8'h03 : 8'h01;
   endfunction

   // Expected truth tables as written for each instance.
   function automatic logic [7:0] exp_entry(input int sel, input int i);
      logic [3:0] ea;
      logic [7:0] eb;
      logic [7:0] ec;
      ea = 4'b1000;
      eb = 8'b1110_1000;
      ec = 8'b10_01_11_00;
      case (sel)
         0:       return {7'b0, ea[i]};
         1:       return {7'b0, eb[i]};
         default: return {6'b0, ec[i*2 +: 2]};
      endcase
   endfunction

   task automatic set_model(input int kind, input int sel);
      int nvec;
      logic [7:0] v;
      nvec = 1 << n_of[sel];
      for (int i = 0; i < 256; i++) model_tbl[i] = 8'h00;
      for (int i = 0; i < nvec; i++) begin
         case (kind)
            K_AND:   v = (i == nvec - 1) ? 8'h01 : 8'h00;
            K_OR:    v = (i != 0) ? 8'h01 : 8'h00;
            K_MAJ:   v = ($countones(i) >= 2) ? 8'h01 : 8'h00;
            K_EXACT: v = exp_entry(sel, i);
            K_RAND:  v = 8'($urandom);
            default: v = exp_entry(sel, i) ^ (($urandom_range(0, 2) == 0) ? 8'hFF : 8'h00);
         endcase
         model_tbl[i] = v & wmask(sel);
      end
   endtask

   // Called at a negedge; leaves at the negedge of the cycle after done.
   task automatic run_sweep(input int sel, input bit ign, input string name);
      int n, s, nvec, t, vdone, err_e, ffi_e, bad_tl, first_bad, dones;
      bit ffv_e, pass_e;
      int miss[$];
      n = n_of[sel]; s = s_of[sel]; nvec = 1 << n; t = nvec * (s + 1);
      for (int i = 0; i < nvec; i++)
         if ((model_tbl[i] & wmask(sel)) != exp_entry(sel, i)) miss.push_back(i);
      pass_e = (miss.size() == 0);
      sel_r = sel;
      start_r = 1'b1;
      @(posedge clk);
      bad_tl = 0; first_bad = -1;
      for (int c = 1; c <= t; c++) begin
         @(negedge clk);
         if (c == 1) start_r = 1'b0;
         if (ign && c == 3) start_r = 1'b1;
         if (ign && c == 4) start_r = 1'b0;
         vdone = (c - 1) / (s + 1);
         err_e = 0;
         foreach (miss[j]) if (miss[j] < vdone) err_e++;
         ffv_e = FFE && (miss.size() > 0) && (miss[0] < vdone);
         ffi_e = ffv_e ? miss[0] : 0;
         if (o_stim !== 8'(vdone) || o_busy !== 1'b1 || o_done !== 1'b0 || o_pass !== 1'b0 ||
             o_err !== 9'(err_e) || o_ffv !== ffv_e || o_ffi !== 8'(ffi_e)) begin
            bad_tl++;
            if (first_bad < 0) first_bad = c;
         end
      end
      total++;
      if (bad_tl != 0) begin
         bad++;
         $display("FAIL %s timeline: %0d bad cycles (first at cycle %0d), required 0", name, bad_tl, first_bad);
      end
      ffv_e = FFE && (miss.size() > 0);
      ffi_e = ffv_e ? miss[0] : 0;
      @(negedge clk);
      if (ign) start_r = 1'b1;
      total++;
      if (o_done !== 1'b1 || o_busy !== 1'b0 || o_stim !== 8'h00) begin
         bad++;
         $display("FAIL %s done_cycle: done=%b busy=%b stim=%0d, required done=1 busy=0 stim=0", name, o_done, o_busy, o_stim);
      end
      total++;
      if (o_err !== 9'(miss.size())) begin
         bad++;
         $display("FAIL %s err_cnt: got %0d, required %0d", name, o_err, miss.size());
      end
      total++;
      if (o_pass !== pass_e) begin
         bad++;
         $display("FAIL %s pass: got %b, required %b", name, o_pass, pass_e);
      end
      total++;
      if (o_ffv !== ffv_e || o_ffi !== 8'(ffi_e)) begin
         bad++;
         $display("FAIL %s first_fail: got vld=%b idx=%0d, required vld=%b idx=%0d", name, o_ffv, o_ffi, ffv_e, ffi_e);
      end
      @(negedge clk);
      if (ign) start_r = 1'b0;
      total++;
      if (o_done !== 1'b0 || o_busy !== 1'b0 || o_pass !== pass_e) begin
         bad++;
         $display("FAIL %s after_done: done=%b busy=%b pass=%b, required done=0 busy=0 pass=%b", name, o_done, o_busy, o_pass, pass_e);
      end
      if (ign) begin
         dones = 0;
         repeat (4) begin
            @(negedge clk);
            if (o_done !== 1'b0 || o_busy !== 1'b0 || o_err !== 9'(miss.size())) dones++;
         end
         total++;
         if (dones != 0) begin
            bad++;
            $display("FAIL %s ignored_start: %0d cycles with restart/done/err change, required 0", name, dones);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start_r = 1'b0;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel_r = s;
         #1;
         total++;
         if (o_stim !== 8'h00 || o_busy !== 1'b0 || o_done !== 1'b0 || o_pass !== 1'b0 ||
             o_err !== 9'h000 || o_ffv !== 1'b0 || o_ffi !== 8'h00) begin
            bad++;
            $display("FAIL reset_state[%0d]: stim=%0d busy=%b done=%b pass=%b err=%0d ffv=%b ffi=%0d, required all 0",
                     s, o_stim, o_busy, o_done, o_pass, o_err, o_ffv, o_ffi);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      sel_r = 0;
   endtask

   task automatic test_and_sweep();
      set_model(K_AND, 0);
      run_sweep(0, 1'b0, "and2");
   endtask

   task automatic test_or_sweep();
      set_model(K_OR, 0);
      run_sweep(0, 1'b0, "or2");
   endtask

   task automatic test_majority();
      set_model(K_MAJ, 1);
      run_sweep(1, 1'b0, "maj3");
   endtask

   task automatic test_ignored_start();
      set_model(K_OR, 0);
      run_sweep(0, 1'b1, "ignore_or2");
      set_model(K_MAJ, 1);
      run_sweep(1, 1'b1, "ignore_maj3");
   endtask

   task automatic test_reset_mid();
      bit seen;
      int noise;
      sel_r = 0;
      set_model(K_OR, 0);
      start_r = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_r = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         if (o_stim === 8'd2) seen = 1'b1;
         else @(negedge clk);
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL reset_mid wait_stim2: stim never reached 2, last stim=%0d", o_stim);
      end else begin
         total++;
         if (o_err !== 9'd1) begin
            bad++;
            $display("FAIL reset_mid pre_err: got %0d, required 1", o_err);
         end
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (o_stim !== 8'h00 || o_busy !== 1'b0 || o_done !== 1'b0 || o_pass !== 1'b0 ||
          o_err !== 9'h000 || o_ffv !== 1'b0 || o_ffi !== 8'h00) begin
         bad++;
         $display("FAIL reset_mid async_clear: stim=%0d busy=%b done=%b pass=%b err=%0d ffv=%b, required all 0",
                  o_stim, o_busy, o_done, o_pass, o_err, o_ffv);
      end
      noise = 0;
      repeat (3) begin
         @(negedge clk);
         if (o_done !== 1'b0 || o_busy !== 1'b0) noise++;
      end
      rst_n = 1'b1;
      total++;
      if (noise != 0) begin
         bad++;
         $display("FAIL reset_mid no_done: %0d cycles with done/busy, required 0", noise);
      end
      set_model(K_AND, 0);
      run_sweep(0, 1'b0, "post_reset");
   endtask

   task automatic test_back_to_back();
      set_model(K_FLIP, 1);
      model_tbl[5] = model_tbl[5] ^ 8'h01;
      run_sweep(1, 1'b0, "b2b_faulty");
      set_model(K_MAJ, 1);
      run_sweep(1, 1'b0, "b2b_clean");
      set_model(K_RAND, 2);
      model_tbl[0] = 8'h02;
      run_sweep(2, 1'b0, "b2b_w2_faulty");
      set_model(K_EXACT, 2);
      run_sweep(2, 1'b0, "b2b_w2_clean");
   endtask

   task automatic test_random();
      int sel, kind;
      for (int it = 0; it < 12; it++) begin
         sel = $urandom_range(0, 2);
         kind = $urandom_range(K_EXACT, K_FLIP);
         set_model(kind, sel);
         run_sweep(sel, ($urandom_range(0, 3) == 0), $sformatf("rand%0d_s%0d_k%0d", it, sel, kind));
      end
   endtask

   initial begin
      test_reset();
      test_and_sweep();
      test_or_sweep();
      test_majority();
      test_ignored_start();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Parametrised exhaustive stimulus generator and response checker for combinational gate modules (Nand/And-style primitives and the N-input gates built from them). On a start pulse it walks all 2^N input vectors with a programmable settle time, compares the DUT output against a packed expected truth table, and reports pass/fail, the mismatch count and the first failing vector. It replaces free-running `always #` toggle stimulus in gate testbenches with a clocked, self-checking, synthesizable sweep.

## Interface
- `N`, 2: number of DUT inputs, 1..8.
- `W`, 1: number of DUT outputs, 1..8.
- `SETTLE`, 1: extra hold cycles per vector before sampling, 0..255.
- `EXPECT`, 4'b1000 (2-input AND): expected truth table, width W*2^N; entry for vector i is `EXPECT[i*W +: W]`.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a sweep; sampled only in IDLE.
- `resp`  in  W  DUT output.
- `stim`  out  N  DUT input vector.
- `busy`  out  1  high while sweeping.
- `done`  out  1  one-cycle pulse at end of sweep.
- `pass`  out  1  high when last sweep had zero mismatches; held until next accepted start.
- `err_cnt`  out  N+1  mismatches in the current/last sweep.
- `first_fail_vld`  out  1  at least one mismatch captured.
- `first_fail_idx`  out  N  index of first mismatching vector.

## Operation
- States: IDLE, APPLY, DONE.
- IDLE: `busy`=0. `start`=1 -> APPLY; clears `err_cnt`, `pass`, `first_fail_*`; vector index 0, settle counter 0.
- APPLY: `stim` = vector index; `busy`=1. Each vector occupies SETTLE+1 cycles. On the clock edge ending the last cycle of a vector, `resp` is compared with `EXPECT[idx*W +: W]`; any bit difference = mismatch -> `err_cnt` +1.
- After index 2^N-1 is sampled -> DONE.
- DONE: one cycle; `done`=1, `busy`=0, `pass` <= (`err_cnt`==0); `stim` returns to 0; -> IDLE.
- `err_cnt` is N+1 bits, max 2^N; no saturation needed.
- Index counter is N bits; termination detected at all-ones, never wraps into a second pass.
- `start` in APPLY or DONE is ignored (no restart, no queuing).
- `stim`, `busy`, `done`, `pass`, `err_cnt`, `first_fail_*` are all registered.

## Timing
- Reset (`rst_n`=0, asynchronous, any state): state IDLE; `stim`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `first_fail_vld`=0, `first_fail_idx`=0. Mid-sweep reset aborts the sweep with no `done`.
- `start` high at edge k -> `busy`=1 and `stim`=0 from k+1.
- Vector i is driven during cycles k+1+i*(SETTLE+1) .. k+(i+1)*(SETTLE+1).
- `done`=1 in cycle k+1+2^N*(SETTLE+1); `busy` low in the same cycle.
- `err_cnt` and `first_fail_*` update on the sampling edge, visible the next cycle; final values are stable when `done`=1.
- DUT is combinational: `resp` must settle within SETTLE+1 cycles of `stim` changing; with SETTLE=0 it must settle within one cycle.
- Back-to-back: `start` is accepted at the earliest one cycle after `done`.

## Configuration
- `TTS_FIRST_FAIL_EN` defined: `first_fail_vld`/`first_fail_idx` capture the index of the first mismatching vector of each sweep; later mismatches do not overwrite them.
- Not defined: capture logic omitted; `first_fail_vld` and `first_fail_idx` are tied 0. All other behaviour is identical.

## Test plan
- N=2, W=1, SETTLE=1, EXPECT=4'b1000, DUT=And, start at cycle 0 -> stim 0,0,1,1,2,2,3,3 over cycles 1–8; `done` in cycle 9; `pass`=1; `err_cnt`=0.
- Same parameters, DUT replaced by OR -> mismatches at vectors 1 and 2; `err_cnt`=2; `pass`=0; with `TTS_FIRST_FAIL_EN` defined `first_fail_vld`=1, `first_fail_idx`=1; without it both are 0.
- N=3, SETTLE=0, EXPECT=8'b1110_1000, DUT=3-input majority -> `busy` for exactly 8 cycles; `pass`=1.
- `start` pulsed again during APPLY and in the DONE cycle -> ignored; exactly one `done`; `err_cnt` is not cleared.
- `rst_n` dropped while `stim`=2 -> all outputs 0 immediately, with no `done`; after release, a new `start` runs a full clean sweep with `pass`=1.
- Faulty sweep followed by a correct sweep -> second `start` clears `pass`, `err_cnt` and `first_fail_*`; final `pass`=1, `err_cnt`=0.
